// File: rtl/priority_select_gen.sv
// Multi-grant priority selector: up to REQS distinct grants per cycle, alternating MSB-first/LSB-first picks, registered outputs.
// Optional simulation-only output checks are enabled by defining PSEL_GEN_CHECK_EN.
module priority_select_gen #(
    parameter int REQS  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [WIDTH-1:0]        req,
    output logic [WIDTH-1:0]        gnt,
    output logic [WIDTH*REQS-1:0]   gnt_bus,
    output logic                    empty
);

    function automatic logic [WIDTH-1:0] lowest_bit(input logic [WIDTH-1:0] v);
        return v & (~v + WIDTH'(1));
    endfunction

    function automatic logic [WIDTH-1:0] highest_bit(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0]      remaining;
    logic [WIDTH-1:0]      pick;
    logic [WIDTH*REQS-1:0] bus_next;
    logic [WIDTH-1:0]      gnt_next;
    logic                  empty_next;

    // Removing each grant from the pool makes the k-th pick equal the (k/2)-th
    // highest/lowest set bit and leaves later selectors at zero once exhausted.
    always_comb begin
        remaining  = req;
        pick       = '0;
        bus_next   = '0;
        gnt_next   = '0;
        empty_next = (req == '0);
        for (int k = 0; k < REQS; k++) begin
            if ((k % 2) == 0) pick = highest_bit(remaining);
            else              pick = lowest_bit(remaining);
            bus_next[k*WIDTH +: WIDTH] = pick;
            gnt_next  = gnt_next | pick;
            remaining = remaining & ~pick;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt     <= '0;
            gnt_bus <= '0;
            empty   <= 1'b1;
        end else begin
            gnt     <= gnt_next;
            gnt_bus <= bus_next;
            empty   <= empty_next;
        end
    end

`ifdef PSEL_GEN_CHECK_EN
    logic [WIDTH-1:0] req_q;
    logic             chk_valid;

    function automatic bit slices_ok(input logic [WIDTH*REQS-1:0] bus);
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] s;
        bit               ok;
        acc = '0;
        ok  = 1'b1;
        for (int k = 0; k < REQS; k++) begin
            s = bus[k*WIDTH +: WIDTH];
            if ($countones(s) > 1) ok = 1'b0;
            if ((acc & s) != '0)   ok = 1'b0;
            acc = acc | s;
        end
        return ok;
    endfunction

    function automatic int expected_count(input logic [WIDTH-1:0] v);
        int pc;
        pc = $countones(v);
        return (pc < REQS) ? pc : REQS;
    endfunction

    // req_q mirrors the request that produced the currently registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q     <= '0;
            chk_valid <= 1'b0;
        end else begin
            req_q     <= req;
            chk_valid <= 1'b1;
        end
    end

    always @(posedge clock) begin
        if (reset_n && chk_valid) begin
            if (!slices_ok(gnt_bus))
                $error("priority_select_gen: grant slices not one-hot/disjoint");
            if ((gnt & ~req_q) != '0)
                $error("priority_select_gen: grant to clear request bit");
            if ($countones(gnt) != expected_count(req_q))
                $error("priority_select_gen: grant count wrong");
            if (empty != (req_q == '0))
                $error("priority_select_gen: empty flag wrong");
        end
    end
`else
    // Default build carries no checking logic.
`endif

endmodule

// File: tb/tb_priority_select_gen.sv
// Scoreboard bench for priority_select_gen: directed cases, full sweep, random traffic and a mid-stream reset.
module tb_priority_select_gen;
    localparam int R = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0]   gnt;
        logic [W*R-1:0] bus;
        logic           empty;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [W-1:0]   req = 8'hFF;
    logic [W-1:0]   gnt;
    logic [W*R-1:0] gnt_bus;
    logic           empty;

    int   passed = 0;
    int   total  = 0;
    exp_t sb_q[$];

    priority_select_gen #(.REQS(R), .WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_bus (gnt_bus),
        .empty   (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s got %h want %h", name, got, want);
    endtask

    // Sorted list of set-bit positions; even selectors take from the top, odd from the bottom.
    function automatic exp_t model(input logic [W-1:0] r);
        int   idx[$];
        int   b;
        exp_t e;
        e = '0;
        for (int i = 0; i < W; i++) if (r[i]) idx.push_back(i);
        e.empty = (idx.size() == 0);
        for (int k = 0; k < R; k++) begin
            if (idx.size() == 0) break;
            if ((k % 2) == 0) b = idx.pop_back();
            else              b = idx.pop_front();
            e.bus[k*W + b] = 1'b1;
            e.gnt[b]       = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(input logic [W-1:0] r, input exp_t e);
        @(negedge clock);
        req = r;
        sb_q.push_back(e);
    endtask

    task automatic drive_model(input logic [W-1:0] r);
        drive(r, model(r));
    endtask

    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (reset_n && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("gnt",     64'(gnt),     64'(e.gnt));
            check("gnt_bus", 64'(gnt_bus), 64'(e.bus));
            check("empty",   64'(empty),   64'(e.empty));
        end
    end

    initial begin
        int wait_cycles;
        repeat (2) @(negedge clock);
        check("reset_gnt",     64'(gnt),     64'h0);
        check("reset_gnt_bus", 64'(gnt_bus), 64'h0);
        check("reset_empty",   64'(empty),   64'h1);

        // Release with req=FF still applied; the first edge must produce C3.
        reset_n = 1'b1;
        sb_q.push_back('{gnt: 8'hC3, bus: 32'h02400180, empty: 1'b0});
        drive(8'hB6, '{gnt: 8'hA6, bus: 32'h04200280, empty: 1'b0});
        drive(8'h01, '{gnt: 8'h01, bus: 32'h00000001, empty: 1'b0});
        drive(8'h03, '{gnt: 8'h03, bus: 32'h00000102, empty: 1'b0});
        drive(8'h00, '{gnt: 8'h00, bus: 32'h00000000, empty: 1'b1});
        drive(8'h80, '{gnt: 8'h80, bus: 32'h00000080, empty: 1'b0});

        for (int i = 0; i < 256; i++) drive_model(W'(i));
        for (int i = 0; i < 200; i++) drive_model(W'($urandom_range(0, 255)));

        // Asynchronous reset between edges discards the pending selection.
        drive_model(8'h5A);
        #2;
        reset_n = 1'b0;
        sb_q.delete();
        #1;
        check("midreset_gnt",     64'(gnt),     64'h0);
        check("midreset_gnt_bus", 64'(gnt_bus), 64'h0);
        check("midreset_empty",   64'(empty),   64'h1);
        repeat (2) @(posedge clock);
        #1;
        check("hold_reset_gnt", 64'(gnt), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        req = 8'h3C;
        sb_q.push_back(model(8'h3C));

        for (int i = 0; i < 100; i++) drive_model(W'($urandom));

        wait_cycles = 0;
        while (sb_q.size() != 0 && wait_cycles < 20) begin
            @(negedge clock);
            wait_cycles++;
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/priority_select_gen.md
# priority_select_gen

Parameterized multi-grant priority selector. Each cycle it picks up to REQS distinct requesters out of a WIDTH-bit request vector. Selection alternates between MSB-first and LSB-first scans. Grants are registered and presented both as a per-selector bus and as a merged vector. It is used by dispatch/issue logic to pick several free entries (RS slots, ROB/free-list entries) per cycle.

## Interface
- REQS, 4: number of grant selectors (≥1).
- WIDTH, 8: number of request lines (≥1).

- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  WIDTH  request vector; bit i set = line i requesting.
- gnt  output  WIDTH  OR of all selector grants; each bit set at most once.
- gnt_bus  output  WIDTH*REQS  selector k's one-hot (or zero) grant in bits [k*WIDTH +: WIDTH].
- empty  output  1  high when req had no set bit.

## Operation
- Selector ordering:
  - Even k scans from the MSB down and picks the (k/2)-th highest set bit (0-based).
  - Odd k scans from the LSB up and picks the ((k-1)/2)-th lowest set bit.
- Selectors are evaluated in order k=0..REQS-1. A bit already granted by a lower k is never granted again.
  - If the remaining set bits are exhausted, the slice for selector k is all-zero.
- Each gnt_bus slice is one-hot or zero. Slices are pairwise disjoint.
- gnt = bitwise OR of all slices. popcount(gnt) = min(popcount(req), REQS).
- gnt is a subset of req. No grant is ever issued to a clear req bit.
- empty = (req == 0). When empty=1, gnt=0 and gnt_bus=0.
- If REQS ≥ popcount(req), every set req bit is granted exactly once.
- Purely positional and stateless: no fairness rotation and no history. The same req always yields the same grants.

## Timing
- The selection network is combinational from req. gnt, gnt_bus and empty are registered on the rising clock edge.
- Latency: one cycle. Outputs after edge n reflect req sampled at edge n.
- No handshake. req may change every cycle, and outputs follow with 1-cycle latency.
- Reset (reset_n=0, asynchronous assert):
  - gnt=0, gnt_bus=0, empty=1 immediately, and held while reset_n=0.
- Reset deassertion: the first valid output appears at the first rising edge with reset_n=1.
- Reset mid-stream: pending selections are discarded.
- req containing X is not supported. Outputs are undefined for it.

## Configuration
- PSEL_GEN_CHECK_EN defined: simulation-only checks at each rising edge when reset_n=1. Each failure reports with $error:
  - each slice is one-hot or zero;
  - slices are disjoint;
  - gnt ⊆ previous req;
  - popcount(gnt) = min(popcount(previous req), REQS);
  - empty ⇔ previous req==0.
- Not defined: checks are absent. Synthesized logic is identical either way.

## Test plan
- Reset: hold reset_n=0 with req=8'hFF → gnt=0, gnt_bus=0, empty=1. Release → next edge gnt=8'hC3.
- req=8'b1011_0110 → one cycle later gnt_bus=32'h04200280, gnt=8'hA6, empty=0.
- req=8'h01 → gnt_bus=32'h00000001, gnt=8'h01. The single bit is granted once, by selector 0 only.
- req=8'h03 → gnt_bus=32'h00000102, gnt=8'h03.
- req=8'h00 → gnt=0, gnt_bus=0, empty=1.
- Exhaustive sweep: req 0..255 incrementing every cycle with PSEL_GEN_CHECK_EN defined → no check fires, and each output matches a reference model one cycle after its req.
